// File: rtl/div.sv
// div: iterative 32-bit signed/unsigned restoring divider; ports clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i -> result_o {rem,quo}, ready_o, stallreq_o
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] dividend, dividend_n;
  logic [31:0] divisor_r, divisor_n;
  logic        neg1, neg1_n, negq, negq_n;
  logic [63:0] result_r, result_n;
  logic [31:0] abs1, abs2, quo, rem;
  logic [33:0] diff;
  assign abs1       = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs2       = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  assign diff       = {1'b0, dividend[64:32]} - {2'b0, divisor_r};
  assign quo        = negq ? -dividend[31:0] : dividend[31:0];
  assign rem        = neg1 ? -dividend[64:33] : dividend[64:33];
  assign ready_o    = state == END;
  assign result_o   = ready_o ? result_r : 64'h0;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dividend_n = dividend;
    divisor_n  = divisor_r;
    neg1_n     = neg1;
    negq_n     = negq;
    result_n   = result_r;
    case (state)
      FREE: if (start_i && !annul_i) begin
        if (opdata2_i == 32'h0) state_n = BYZERO;
        else begin
          state_n    = ON;
          cnt_n      = 6'd0;
          dividend_n = {32'h0, abs1, 1'b0};
          divisor_n  = abs2;
          neg1_n     = signed_div_i & opdata1_i[31];
          negq_n     = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
        end
      end
      BYZERO: begin
        state_n  = END;
        result_n = 64'h0;
      end
      ON: if (annul_i) state_n = FREE;
      else if (cnt != 6'd32) begin
        cnt_n      = cnt + 6'd1;
        dividend_n = diff[33] ? {dividend[63:0], 1'b0} : {diff[31:0], dividend[31:0], 1'b1};
      end else begin
        state_n  = END;
        cnt_n    = 6'd0;
        result_n = {rem, quo};
      end
      default: state_n = start_i ? END : FREE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FREE;
      cnt       <= 6'd0;
      dividend  <= 65'h0;
      divisor_r <= 32'h0;
      neg1      <= 1'b0;
      negq      <= 1'b0;
      result_r  <= 64'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dividend  <= dividend_n;
      divisor_r <= divisor_n;
      neg1      <= neg1_n;
      negq      <= negq_n;
      result_r  <= result_n;
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the iterative divider
module tb_div;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'h0;
  logic [31:0] opdata2_i = 32'h0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  int          n_chk = 0;
  int          n_fail = 0;
  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic finish_op(input string tag, input logic [63:0] exp, input int exp_n, input int hold);
    int n;
    logic bad;
    #1 bad = !stallreq_o;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
      if (!ready_o && !stallreq_o) bad = 1'b1;
    end while (!ready_o && n < 100);
    check({tag, "_edges"}, 64'(n), 64'(exp_n));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_stall_busy"}, {63'h0, bad}, 64'h0);
    check({tag, "_stall_done"}, {63'h0, stallreq_o}, 64'h0);
    repeat (hold) begin
      @(posedge clk);
      #1 check({tag, "_hold"}, result_o | {63'h0, !ready_o}, exp);
    end
    @(negedge clk) start_i = 1'b0;
    @(posedge clk);
    #1 check({tag, "_clr"}, result_o | {63'h0, ready_o}, 64'h0);
  endtask
  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
  endtask
  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int exp_n, input int hold);
    drive(s, a, b);
    finish_op(tag, exp, exp_n, hold);
  endtask
  initial begin
    #1000000 $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    check("reset_stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk) rst = 1'b0;
    run("u_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 5);
    run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 0);
    run("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 34, 0);
    run("byzero", 1'b0, 32'h1234, 32'h0, 64'h0, 2, 2);
    run("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);
    run("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, 0);
    run("u_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 34, 0);
    drive(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    @(negedge clk) annul_i = 1'b1;
    #1 check("annul_stall", {63'h0, stallreq_o}, 64'h0);
    @(posedge clk);
    #1 check("annul_ready", {63'h0, ready_o}, 64'h0);
    @(negedge clk) annul_i = 1'b0;
    finish_op("annul_restart", {32'd2, 32'd14}, 34, 0);
    drive(1'b0, 32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_ready", {63'h0, ready_o}, 64'h0);
    check("rst_result", result_o, 64'h0);
    @(negedge clk) rst = 1'b0;
    finish_op("rst_restart", {32'd1, 32'd333}, 34, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
